// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: widths, opcodes, FSM states, flag indices.
package cpu_pkg;

  localparam int unsigned DW     = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned OPW    = 4;
  localparam int unsigned NFLAGS = 4;
  localparam int unsigned CNT_W  = $clog2(DW) + 1;

  localparam logic [OPW-1:0] OP_ADD = 4'h0;
  localparam logic [OPW-1:0] OP_SUB = 4'h1;
  localparam logic [OPW-1:0] OP_AND = 4'h2;
  localparam logic [OPW-1:0] OP_OR  = 4'h3;
  localparam logic [OPW-1:0] OP_XOR = 4'h4;
  localparam logic [OPW-1:0] OP_NOT = 4'h5;
  localparam logic [OPW-1:0] OP_SHL = 4'h6;
  localparam logic [OPW-1:0] OP_SHR = 4'h7;
  localparam logic [OPW-1:0] OP_SRA = 4'h8;
  localparam logic [OPW-1:0] OP_MUL = 4'h9;
  localparam logic [OPW-1:0] OP_MOV = 4'hA;
  localparam logic [OPW-1:0] OP_CMP = 4'hB;

  // Bit positions inside the {Z,N,C,V} flag vector
  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    WB   = 2'd2
  } state_e;

  function automatic logic is_legal(input logic [OPW-1:0] op);
    return op <= OP_CMP;
  endfunction

  // CMP and undefined opcodes never touch the register file
  function automatic logic writes_back(input logic [OPW-1:0] op);
    return is_legal(op) && (op != OP_CMP);
  endfunction

  // Shifts by zero complete in the single-cycle path
  function automatic logic is_iter(input logic [OPW-1:0] op, input logic [3:0] amt);
    return (op == OP_MUL) ||
           (((op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA)) && (amt != 4'd0));
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shifter (1 bit/cycle) and shift-add multiplier (DW cycles).
// The first step is applied while loading, so an N-step operation shows
// done during the N-th cycle after start.
// Ports: start (load op/a/b), op, a, b (b[3:0] = shift amount),
//        done (result final this cycle), result, carry.
module alu_iter_unit
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] op,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  output logic           done,
  output logic [DW-1:0]  result,
  output logic           carry
);

  logic             active_q, active_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [DW-1:0]    lo_q, lo_d;
  logic [DW-1:0]    hi_q, hi_d;
  logic [DW-1:0]    mc_q, mc_d;
  logic             cy_q, cy_d;

  logic [OPW-1:0]   src_op;
  logic [DW-1:0]    src_lo, src_hi, src_mc;
  logic             src_cy;
  logic [DW-1:0]    step_lo, step_hi;
  logic             step_cy;
  logic [DW:0]      mul_sum;

  // One shift / shift-add step on either freshly loaded operands or current state
  always_comb begin
    src_op = op_q;
    src_lo = lo_q;
    src_hi = hi_q;
    src_mc = mc_q;
    src_cy = cy_q;
    if (start) begin
      src_op = op;
      src_mc = a;
      src_hi = '0;
      src_cy = 1'b0;
      src_lo = (op == OP_MUL) ? b : a;
    end

    step_lo = src_lo;
    step_hi = src_hi;
    step_cy = src_cy;
    mul_sum = '0;
    case (src_op)
      OP_SHL: begin
        step_cy = src_lo[DW-1];
        step_lo = {src_lo[DW-2:0], 1'b0};
      end
      OP_SHR: begin
        step_cy = src_lo[0];
        step_lo = {1'b0, src_lo[DW-1:1]};
      end
      OP_SRA: begin
        step_cy = src_lo[0];
        step_lo = {src_lo[DW-1], src_lo[DW-1:1]};
      end
      OP_MUL: begin
        // {hi,lo} holds partial product in hi and remaining multiplier in lo
        mul_sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_mc} : {(DW+1){1'b0}});
        step_hi = mul_sum[DW:1];
        step_lo = {mul_sum[0], src_lo[DW-1:1]};
      end
      default: ;
    endcase
  end

  // Sequencing: load+step on start, step until count expires, then release
  always_comb begin
    active_d = active_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    mc_d     = mc_q;
    cy_d     = cy_q;
    if (start) begin
      active_d = 1'b1;
      op_d     = op;
      mc_d     = a;
      lo_d     = step_lo;
      hi_d     = step_hi;
      cy_d     = step_cy;
      cnt_d    = (op == OP_MUL) ? CNT_W'(DW - 1) : (CNT_W'(b[3:0]) - CNT_W'(1));
      done_d   = (cnt_d == '0);
    end else if (active_q) begin
      if (done_q) begin
        active_d = 1'b0;
        done_d   = 1'b0;
      end else begin
        lo_d   = step_lo;
        hi_d   = step_hi;
        cy_d   = step_cy;
        cnt_d  = cnt_q - CNT_W'(1);
        done_d = (cnt_q == CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      mc_q     <= '0;
      cy_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      mc_q     <= mc_d;
      cy_q     <= cy_d;
    end
  end

  assign done   = done_q;
  assign result = lo_q;
  // MUL carry reports a truncated product (any upper bit set)
  assign carry  = (op_q == OP_MUL) ? (|hi_q) : cy_q;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage behind the 16x16 register file: single-cycle ALU, iterative
// shift/MUL, one-cycle register-file write-back strobe and Z/N/C/V flags.
// Ports: in_valid/in_ready handshake with opcode/dest/op_a/op_b;
//        wb_enable/wb_reg/wb_data to the register file write port;
//        flags {Z,N,C,V}; busy (op in flight); illegal (undefined opcode pulse).
module alu_exec_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    opcode,
  input  logic [AW-1:0]     dest,
  input  logic [DW-1:0]     op_a,
  input  logic [DW-1:0]     op_b,
  output logic              wb_enable,
  output logic [AW-1:0]     wb_reg,
  output logic [DW-1:0]     wb_data,
  output logic [NFLAGS-1:0] flags,
  output logic              busy,
  output logic              illegal
);

  state_e            state_q, state_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [AW-1:0]     dest_q, dest_d;
  logic [DW-1:0]     res_q, res_d;
  logic              c_q, c_d;
  logic              v_q, v_d;
  logic              wb_en_q, wb_en_d;
  logic [AW-1:0]     wb_reg_q, wb_reg_d;
  logic [DW-1:0]     wb_data_q, wb_data_d;
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;
  logic              ill_q, ill_d;

  logic              transfer_c;
  logic              start_c;
  logic              iter_done;
  logic [DW-1:0]     iter_res;
  logic              iter_carry;

  logic [DW:0]       sum_c, diff_c;
  logic [DW-1:0]     alu_res_c;
  logic              alu_c_c, alu_v_c;

  assign transfer_c = in_valid && rdy_q;

  // Single-cycle ALU on the live operands (only used at transfer)
  always_comb begin
    sum_c     = {1'b0, op_a} + {1'b0, op_b};
    diff_c    = {1'b0, op_a} - {1'b0, op_b};
    alu_res_c = '0;
    alu_c_c   = 1'b0;
    alu_v_c   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res_c = sum_c[DW-1:0];
        alu_c_c   = sum_c[DW];
        alu_v_c   = (op_a[DW-1] == op_b[DW-1]) && (alu_res_c[DW-1] != op_a[DW-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res_c = diff_c[DW-1:0];
        alu_c_c   = diff_c[DW];
        alu_v_c   = (op_a[DW-1] != op_b[DW-1]) && (alu_res_c[DW-1] != op_a[DW-1]);
      end
      OP_AND:                 alu_res_c = op_a & op_b;
      OP_OR:                  alu_res_c = op_a | op_b;
      OP_XOR:                 alu_res_c = op_a ^ op_b;
      OP_NOT:                 alu_res_c = ~op_a;
      OP_MOV:                 alu_res_c = op_b;
      OP_SHL, OP_SHR, OP_SRA: alu_res_c = op_a;  // zero-amount shift
      default:                alu_res_c = '0;
    endcase
  end

  alu_iter_unit u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_c),
    .op     (opcode),
    .a      (op_a),
    .b      (op_b),
    .done   (iter_done),
    .result (iter_res),
    .carry  (iter_carry)
  );

  // FSM next state, capture registers and registered outputs
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dest_d    = dest_q;
    res_d     = res_q;
    c_d       = c_q;
    v_d       = v_q;
    wb_en_d   = 1'b0;
    wb_reg_d  = '0;
    wb_data_d = '0;
    ill_d     = 1'b0;
    start_c   = 1'b0;
    flags_d   = flags_q;

    case (state_q)
      IDLE: begin
        if (transfer_c) begin
          op_d   = opcode;
          dest_d = dest;
          if (is_iter(opcode, op_b[3:0])) begin
            start_c = 1'b1;
            state_d = ITER;
          end else begin
            state_d = WB;
            res_d   = alu_res_c;
            c_d     = alu_c_c;
            v_d     = alu_v_c;
            ill_d   = !is_legal(opcode);
            if (writes_back(opcode)) begin
              wb_en_d   = 1'b1;
              wb_reg_d  = dest;
              wb_data_d = alu_res_c;
            end
          end
        end
      end
      ITER: begin
        if (iter_done) begin
          state_d   = WB;
          res_d     = iter_res;
          c_d       = iter_carry;
          v_d       = 1'b0;
          wb_en_d   = 1'b1;
          wb_reg_d  = dest_q;
          wb_data_d = iter_res;
        end
      end
      WB: begin
        state_d = IDLE;
        if (is_legal(op_q)) begin
          flags_d[FLAG_Z] = (res_q == '0);
          flags_d[FLAG_N] = res_q[DW-1];
          flags_d[FLAG_C] = c_q;
          flags_d[FLAG_V] = v_q;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      dest_q    <= '0;
      res_q     <= '0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
      flags_q   <= '0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      res_q     <= res_d;
      c_q       <= c_d;
      v_q       <= v_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      flags_q   <= flags_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      ill_q     <= ill_d;
    end
  end

  assign in_ready  = rdy_q;
  assign wb_enable = wb_en_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;
  assign flags     = flags_q;
  assign busy      = busy_q;
  assign illegal   = ill_q;

endmodule
